// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SPI-mode SD initiator.
package sd_spi_pkg;

    typedef enum logic [1:0] {B_IDLE, B_LOW, B_HIGH, B_DONE} byte_state_t;
    typedef enum logic [1:0] {C_IDLE, C_SEND, C_POLL, C_FINISH} cmd_state_t;

    localparam logic [1:0] CMD_START_BITS = 2'b01;
    localparam logic [7:0] CRC_CMD0       = 8'h95;
    localparam logic [7:0] CRC_CMD8       = 8'h87;
    localparam logic [7:0] CRC_DEFAULT    = 8'h01;
    localparam logic [7:0] POLL_BYTE      = 8'hFF;

    // Only CMD0 and CMD8 are CRC-checked in SPI mode; anything else just needs the end bit.
    function automatic logic [7:0] cmd_crc(input logic [5:0] idx);
        case (idx)
            6'd0:    return CRC_CMD0;
            6'd8:    return CRC_CMD8;
            default: return CRC_DEFAULT;
        endcase
    endfunction

endpackage

// File: rtl/sd_spi_initiator_byte.sv
// SPI mode 0 byte engine: SCK divider, MSB-first shifter and bit counter.
module sd_spi_byte
    import sd_spi_pkg::*;
#(
    parameter int DIV_SLOW = 64,
    parameter int DIV_FAST = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       start,
    input  logic       fast_sel,
    input  logic [7:0] tx,
    input  logic       miso,
    output logic [7:0] rx,
    output logic       done,
    output logic       active,
    output logic       sck,
    output logic       mosi
);

    localparam int DIV_MAX = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
    localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

    byte_state_t      state;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_last;  // half-period minus one, latched per byte
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;     // tx bits leave at the top, miso bits enter at the bottom

    assign active = (state != B_IDLE);

    // Byte sequencing: each LOW and HIGH phase lasts div_last+1 cycles, DONE lasts one.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= B_IDLE;
            div_cnt  <= '0;
            div_last <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx       <= 8'hFF;
            done     <= 1'b0;
            sck      <= 1'b0;
            mosi     <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                B_IDLE: begin
                    if (start) begin
                        div_last <= fast_sel ? CNT_W'(DIV_FAST - 1) : CNT_W'(DIV_SLOW - 1);
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        shift    <= tx;
                        mosi     <= tx[7];
                        state    <= B_LOW;
                    end
                end
                B_LOW: begin
                    if (div_cnt == div_last) begin
                        div_cnt <= '0;
                        sck     <= 1'b1;
                        shift   <= {shift[6:0], miso};
                        state   <= B_HIGH;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                B_HIGH: begin
                    if (div_cnt == div_last) begin
                        div_cnt <= '0;
                        sck     <= 1'b0;
                        if (bit_cnt == 3'd7) begin
                            mosi  <= 1'b1;
                            rx    <= shift;
                            done  <= 1'b1;
                            state <= B_DONE;
                        end else begin
                            mosi    <= shift[7];
                            bit_cnt <= bit_cnt + 3'd1;
                            state   <= B_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                default: state <= B_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sd_spi_initiator.sv
// SPI-mode SD host: command sequencer, R1 polling, chip select and start arbitration.
module sd_spi_initiator
    import sd_spi_pkg::*;
#(
    parameter int DIV_SLOW     = 64,
    parameter int DIV_FAST     = 2,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        fast_sel,
    input  logic        cs_en,
    input  logic        byte_start,
    input  logic [7:0]  byte_tx,
    output logic [7:0]  byte_rx,
    output logic        byte_done,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        cmd_done,
    output logic [7:0]  cmd_r1,
    output logic        cmd_timeout,
    output logic        busy,
    output logic        sck,
    output logic        mosi,
    input  logic        miso,
    output logic        ss
);

    localparam int PW = $clog2(RESP_TIMEOUT + 1);

    cmd_state_t     cmd_state;
    logic [5:0]     idx_q;
    logic [31:0]    arg_q;
    logic [2:0]     send_cnt;
    logic [PW-1:0]  poll_cnt;
    logic           eng_go;
    logic [7:0]     seq_tx;
    logic           eng_active;
    logic           cmd_acc;
    logic           byte_acc;
    logic           eng_start;
    logic [7:0]     eng_tx;

    function automatic logic [7:0] cmd_byte(input logic [5:0] idx, input logic [31:0] arg,
                                            input logic [2:0] n);
        case (n)
            3'd0:    return {CMD_START_BITS, idx};
            3'd1:    return arg[31:24];
            3'd2:    return arg[23:16];
            3'd3:    return arg[15:8];
            3'd4:    return arg[7:0];
            default: return cmd_crc(idx);
        endcase
    endfunction

    // A command and a raw byte never overlap, so a single busy gates both starts.
    assign busy      = eng_active | (cmd_state != C_IDLE);
    assign cmd_acc   = cmd_start & ~busy;
    assign byte_acc  = byte_start & ~busy & ~cmd_start;
    assign eng_start = byte_acc | eng_go;
    assign eng_tx    = eng_go ? seq_tx : byte_tx;

    sd_spi_byte #(.DIV_SLOW(DIV_SLOW), .DIV_FAST(DIV_FAST)) u_byte (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .start    (eng_start),
        .fast_sel (fast_sel),
        .tx       (eng_tx),
        .miso     (miso),
        .rx       (byte_rx),
        .done     (byte_done),
        .active   (eng_active),
        .sck      (sck),
        .mosi     (mosi)
    );

    // Chip select follows cs_en one cycle late, independent of any transfer.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) ss <= 1'b1;
        else       ss <= ~cs_en;
    end

    // Command sequencer: six command bytes, then 0xFF polls until an R1 or the timeout.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cmd_state   <= C_IDLE;
            idx_q       <= '0;
            arg_q       <= '0;
            send_cnt    <= '0;
            poll_cnt    <= '0;
            eng_go      <= 1'b0;
            seq_tx      <= POLL_BYTE;
            cmd_r1      <= 8'hFF;
            cmd_timeout <= 1'b0;
            cmd_done    <= 1'b0;
        end else begin
            eng_go   <= 1'b0;
            cmd_done <= 1'b0;
            case (cmd_state)
                C_IDLE: begin
                    if (cmd_acc) begin
                        idx_q       <= cmd_index;
                        arg_q       <= cmd_arg;
                        send_cnt    <= '0;
                        poll_cnt    <= '0;
                        cmd_r1      <= 8'hFF;
                        cmd_timeout <= 1'b0;
                        seq_tx      <= {CMD_START_BITS, cmd_index};
                        eng_go      <= 1'b1;
                        cmd_state   <= C_SEND;
                    end
                end
                C_SEND: begin
                    if (byte_done) begin
                        eng_go <= 1'b1;
                        if (send_cnt == 3'd5) begin
                            seq_tx    <= POLL_BYTE;
                            cmd_state <= C_POLL;
                        end else begin
                            seq_tx   <= cmd_byte(idx_q, arg_q, send_cnt + 3'd1);
                            send_cnt <= send_cnt + 3'd1;
                        end
                    end
                end
                C_POLL: begin
                    if (byte_done) begin
                        if (!byte_rx[7]) begin
                            cmd_r1    <= byte_rx;
                            cmd_done  <= 1'b1;
                            cmd_state <= C_FINISH;
                        end else if (poll_cnt == PW'(RESP_TIMEOUT - 1)) begin
                            cmd_r1      <= 8'hFF;
                            cmd_timeout <= 1'b1;
                            cmd_done    <= 1'b1;
                            cmd_state   <= C_FINISH;
                        end else begin
                            poll_cnt <= poll_cnt + PW'(1);
                            eng_go   <= 1'b1;
                        end
                    end
                end
                default: cmd_state <= C_IDLE;
            endcase
        end
    end

endmodule
